// File: rtl/alu_operand_stage.sv
// alu_operand_stage: single-entry ID/EX register in front of the ALU.
// Captures decoded instructions over a valid/ready handshake, forwards
// EX/MEM and MEM/WB results into the operands at capture, and keeps
// re-forwarding the held operands while the entry is stalled.
module alu_operand_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [4:0]      rs1Addr_in,
    input  logic [4:0]      rs2Addr_in,
    input  logic [4:0]      rdAddr_in,
    input  logic [XLEN-1:0] rs1Data_in,
    input  logic [XLEN-1:0] rs2Data_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic            aluSrc_in,
    input  logic [2:0]      aluOpcode_in,
    input  logic            regWrite_in,
    input  logic            flush_in,
    input  logic            exMemRegWrite_in,
    input  logic [4:0]      exMemRd_in,
    input  logic [XLEN-1:0] exMemResult_in,
    input  logic            memWbRegWrite_in,
    input  logic [4:0]      memWbRd_in,
    input  logic [XLEN-1:0] memWbResult_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] operand1_out,
    output logic [XLEN-1:0] operand2_out,
    output logic [XLEN-1:0] storeData_out,
    output logic [2:0]      aluOpcode_out,
    output logic [4:0]      rdAddr_out,
    output logic            regWrite_out
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, stateNext;

    // Held source indices and operand-2 select, needed to re-forward under stall.
    logic [4:0] rs1AddrQ, rs2AddrQ;
    logic       aluSrcQ;

    logic capture, refresh;
    logic [XLEN-1:0] capOp1, capStore, refOp1, refStore;

    // x0 reads as zero; the younger EX/MEM result beats MEM/WB.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr,
                                            input logic [XLEN-1:0] data,
                                            input logic exWr, input logic [4:0] exRd,
                                            input logic [XLEN-1:0] exRes,
                                            input logic wbWr, input logic [4:0] wbRd,
                                            input logic [XLEN-1:0] wbRes);
        if (addr == 5'd0)                fwd = '0;
        else if (exWr && exRd == addr)   fwd = exRes;
        else if (wbWr && wbRd == addr)   fwd = wbRes;
        else                             fwd = data;
    endfunction

    assign valid_out = (state == FULL);
    assign ready_out = ~valid_out | ready_in;
    assign capture   = valid_in & ready_out & ~flush_in;
    // A held entry that is neither leaving nor being replaced.
    assign refresh   = valid_out & ~ready_in & ~flush_in;

    // Forwarded operand values for a new capture and for a held entry.
    always_comb begin
        capOp1   = fwd(rs1Addr_in, rs1Data_in, exMemRegWrite_in, exMemRd_in,
                       exMemResult_in, memWbRegWrite_in, memWbRd_in, memWbResult_in);
        capStore = fwd(rs2Addr_in, rs2Data_in, exMemRegWrite_in, exMemRd_in,
                       exMemResult_in, memWbRegWrite_in, memWbRd_in, memWbResult_in);
        refOp1   = fwd(rs1AddrQ, operand1_out, exMemRegWrite_in, exMemRd_in,
                       exMemResult_in, memWbRegWrite_in, memWbRd_in, memWbResult_in);
        refStore = fwd(rs2AddrQ, storeData_out, exMemRegWrite_in, exMemRd_in,
                       exMemResult_in, memWbRegWrite_in, memWbRd_in, memWbResult_in);
    end

    // Occupancy register.
    always_ff @(posedge clk_in) begin
        if (reset_in) state <= EMPTY;
        else          state <= stateNext;
    end

    // Next occupancy: flush kills, capture fills, drain empties.
    always_comb begin
        stateNext = state;
        if (flush_in)                   stateNext = EMPTY;
        else if (capture)               stateNext = FULL;
        else if (valid_out && ready_in) stateNext = EMPTY;
    end

    // Payload registers: load on capture, re-forward while stalled.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            operand1_out  <= '0;
            operand2_out  <= '0;
            storeData_out <= '0;
            aluOpcode_out <= 3'b111;
            rdAddr_out    <= 5'd0;
            regWrite_out  <= 1'b0;
            rs1AddrQ      <= 5'd0;
            rs2AddrQ      <= 5'd0;
            aluSrcQ       <= 1'b0;
        end else if (flush_in) begin
            regWrite_out  <= 1'b0;
        end else if (capture) begin
            operand1_out  <= capOp1;
            storeData_out <= capStore;
            operand2_out  <= aluSrc_in ? imm_in : capStore;
            aluOpcode_out <= aluOpcode_in;
            rdAddr_out    <= rdAddr_in;
            regWrite_out  <= regWrite_in;
            rs1AddrQ      <= rs1Addr_in;
            rs2AddrQ      <= rs2Addr_in;
            aluSrcQ       <= aluSrc_in;
        end else if (refresh) begin
            operand1_out  <= refOp1;
            storeData_out <= refStore;
            if (!aluSrcQ) operand2_out <= refStore;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: handshake, forwarding priority,
// stall refresh, immediate select, back-to-back flow, flush and reset.
module tb_alu_operand_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            vIn, rdyOut, flush, aluSrc, regWr, rdyIn, vOut, regWrOut;
    logic [4:0]      rs1, rs2, rd, rdOut;
    logic [XLEN-1:0] d1, d2, imm, op1, op2, stData;
    logic [2:0]      opc, opcOut;
    logic            exWr, wbWr;
    logic [4:0]      exRd, wbRd;
    logic [XLEN-1:0] exRes, wbRes;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(XLEN)) dut (
        .clk_in(clk), .reset_in(rst), .valid_in(vIn), .ready_out(rdyOut),
        .rs1Addr_in(rs1), .rs2Addr_in(rs2), .rdAddr_in(rd),
        .rs1Data_in(d1), .rs2Data_in(d2), .imm_in(imm), .aluSrc_in(aluSrc),
        .aluOpcode_in(opc), .regWrite_in(regWr), .flush_in(flush),
        .exMemRegWrite_in(exWr), .exMemRd_in(exRd), .exMemResult_in(exRes),
        .memWbRegWrite_in(wbWr), .memWbRd_in(wbRd), .memWbResult_in(wbRes),
        .valid_out(vOut), .ready_in(rdyIn),
        .operand1_out(op1), .operand2_out(op2), .storeData_out(stData),
        .aluOpcode_out(opcOut), .rdAddr_out(rdOut), .regWrite_out(regWrOut)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vIn = 0; flush = 0; aluSrc = 0; regWr = 0; rdyIn = 1;
        rs1 = 0; rs2 = 0; rd = 0; d1 = 0; d2 = 0; imm = 0; opc = 3'b111;
        exWr = 0; wbWr = 0; exRd = 0; wbRd = 0; exRes = 0; wbRes = 0;
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".valid"}, {63'd0, vOut}, 64'd0);
        check({tag, ".op1"}, op1, 64'd0);
        check({tag, ".op2"}, op2, 64'd0);
        check({tag, ".store"}, stData, 64'd0);
        check({tag, ".opc"}, {61'd0, opcOut}, 64'd7);
        check({tag, ".rd"}, {59'd0, rdOut}, 64'd0);
        check({tag, ".regWr"}, {63'd0, regWrOut}, 64'd0);
        check({tag, ".ready"}, {63'd0, rdyOut}, 64'd1);
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        check("rst.readyDuring", {63'd0, rdyOut}, 64'd1);
        step();
        rst = 0;
        checkReset("rst");

        // Basic flow: x3=5, x4=7, ADD
        vIn = 1; rs1 = 3; d1 = 5; rs2 = 4; d2 = 7; opc = 3'b111; rd = 10; regWr = 1;
        step();
        vIn = 0;
        check("basic.valid", {63'd0, vOut}, 64'd1);
        check("basic.op1", op1, 64'd5);
        check("basic.op2", op2, 64'd7);
        check("basic.opc", {61'd0, opcOut}, 64'd7);
        check("basic.rd", {59'd0, rdOut}, 64'd10);
        check("basic.regWr", {63'd0, regWrOut}, 64'd1);
        step();
        check("basic.drain", {63'd0, vOut}, 64'd0);

        // Forward priority
        vIn = 1; rs1 = 5; d1 = 64'h11; opc = 3'b000;
        exWr = 1; exRd = 5; exRes = 64'hAA; wbWr = 1; wbRd = 5; wbRes = 64'hBB;
        step();
        check("fwd.exPrio", op1, 64'hAA);
        check("fwd.opcSub", {61'd0, opcOut}, 64'd0);
        exWr = 0;
        step();
        check("fwd.wbOnly", op1, 64'hBB);
        rs1 = 0; d1 = 64'h33; exWr = 1; exRd = 0; exRes = 64'h99;
        step();
        check("fwd.x0", op1, 64'd0);
        idle();
        step();
        check("fwd.drain", {63'd0, vOut}, 64'd0);

        // Stall refresh: rs2=x6 stale 1, exMem writes x6=0x42 mid-stall
        rdyIn = 0; vIn = 1; rs1 = 1; d1 = 2; rs2 = 6; d2 = 1; aluSrc = 0;
        step();
        vIn = 0;
        check("stall.c1.ready", {63'd0, rdyOut}, 64'd0);
        check("stall.c1.op2", op2, 64'd1);
        exWr = 1; exRd = 6; exRes = 64'h42;
        check("stall.c2.ready", {63'd0, rdyOut}, 64'd0);
        step();
        exWr = 0;
        check("stall.c3.op2", op2, 64'h42);
        check("stall.c3.store", stData, 64'h42);
        check("stall.c3.op1", op1, 64'd2);
        check("stall.c3.valid", {63'd0, vOut}, 64'd1);
        check("stall.c3.ready", {63'd0, rdyOut}, 64'd0);
        step();
        check("stall.hold.op2", op2, 64'h42);
        rdyIn = 1;
        step();
        check("stall.drain", {63'd0, vOut}, 64'd0);

        // Immediate: imm=-4, rs2=x2 forwarded 9 from MEM/WB
        vIn = 1; aluSrc = 1; imm = -64'sd4; rs2 = 2; d2 = 0; wbWr = 1; wbRd = 2; wbRes = 9;
        step();
        idle();
        check("imm.op2", op2, 64'hFFFF_FFFF_FFFF_FFFC);
        check("imm.store", stData, 64'd9);

        // Back-to-back: four captures, no bubble
        for (int i = 0; i < 4; i++) begin
            vIn = 1; rs1 = 5'(8 + i); d1 = 64'(100 + i); rd = 5'(i + 1);
            step();
            check("b2b.valid", {63'd0, vOut}, 64'd1);
            check("b2b.op1", op1, 64'(100 + i));
            check("b2b.rd", {59'd0, rdOut}, 64'(i + 1));
        end
        idle();
        step();
        check("b2b.end", {63'd0, vOut}, 64'd0);

        // Flush while FULL with a would-be capture
        vIn = 1; rs1 = 7; d1 = 64'h77; regWr = 1;
        step();
        check("flush.pre", {63'd0, vOut}, 64'd1);
        d1 = 64'h55; flush = 1;
        step();
        idle();
        check("flush.valid", {63'd0, vOut}, 64'd0);
        check("flush.regWr", {63'd0, regWrOut}, 64'd0);
        check("flush.noCap", op1, 64'h77);

        // Reset mid-stall
        rdyIn = 0; vIn = 1; rs1 = 9; d1 = 64'h123; rs2 = 3; d2 = 64'h456;
        opc = 3'b011; rd = 17; regWr = 1;
        step();
        vIn = 0;
        step();
        check("rstStall.full", {63'd0, vOut}, 64'd1);
        rst = 1;
        step();
        rst = 0;
        idle();
        checkReset("rstStall");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
